// File: rtl/baccarat_pkg.sv
// ============================================================================
// baccarat_pkg : round-state encoding and scoring thresholds for baccarat.
// Rev 1.0
// ============================================================================
`default_nettype none

package baccarat_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    P1    = 4'd1,
    D1    = 4'd2,
    P2    = 4'd3,
    D2    = 4'd4,
    CHK   = 4'd5,
    P3    = 4'd6,
    BCHK  = 4'd7,
    D3    = 4'd8,
    SCORE = 4'd9,
    DONE  = 4'd10
  } state_e;

  localparam logic [3:0] NATURAL_MIN      = 4'd8;
  localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;
  localparam logic [3:0] DEALER_STAND     = 4'd7;

endpackage

`default_nettype wire

// File: rtl/banker_draw_rule.sv
// ============================================================================
// banker_draw_rule : banker third-card decision after the player has drawn.
// Rev 1.0
// ============================================================================
`default_nettype none

module banker_draw_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  always_comb begin
    draw = 1'b0;
    if (dscore < 4'd3) begin
      draw = 1'b1;
    end else if (dscore >= DEALER_STAND) begin
      draw = 1'b0;
    end else begin
      case (dscore)
        4'd3:    draw = (pcard3 != 4'd8);
        4'd4:    draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
        4'd5:    draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
        4'd6:    draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
        default: draw = 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/baccarat_controller.sv
// ============================================================================
// baccarat_controller : round FSM issuing card-load strobes and win lights.
// Optional AUTO_RESTART_EN: restart the round after HOLD_CYCLES in DONE.
// Rev 1.0
// ============================================================================
`default_nettype none

module baccarat_controller
  import baccarat_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic [3:0] pscore_in,
  input  logic [3:0] dscore_in,
  input  logic [3:0] pcard3_in,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       round_done
);

  state_e state_q, state_d;
  logic   player_win_q, player_win_d;
  logic   dealer_win_q, dealer_win_d;
  logic   banker_draw;

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_hold_range_check
    $error("HOLD_CYCLES must lie in 1..255");
  end

  banker_draw_rule u_banker_draw_rule (
    .dscore (dscore_in),
    .pcard3 (pcard3_in),
    .draw   (banker_draw)
  );

`ifdef AUTO_RESTART_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  logic [7:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    hold_cnt_d = (state_q == DONE) ? hold_cnt_q + 8'd1 : 8'd0;
  end

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) hold_cnt_q <= 8'd0;
    else       hold_cnt_q <= hold_cnt_d;
  end
`endif

  always_comb begin
    state_d      = state_q;
    player_win_d = player_win_q;
    dealer_win_d = dealer_win_q;
    case (state_q)
      IDLE: state_d = P1;
      P1:   state_d = D1;
      D1:   state_d = P2;
      P2:   state_d = D2;
      D2:   state_d = CHK;
      // Out-of-range scores (10..15) fall into the natural branch.
      CHK: begin
        if (pscore_in >= NATURAL_MIN || dscore_in >= NATURAL_MIN) state_d = SCORE;
        else if (pscore_in < PLAYER_STAND_MIN)                    state_d = P3;
        else if (dscore_in < PLAYER_STAND_MIN)                    state_d = D3;
        else                                                      state_d = SCORE;
      end
      P3:   state_d = BCHK;
      BCHK: state_d = banker_draw ? D3 : SCORE;
      D3:   state_d = SCORE;
      SCORE: begin
        player_win_d = (pscore_in >= dscore_in);
        dealer_win_d = (dscore_in >= pscore_in);
        state_d      = DONE;
      end
      DONE: begin
`ifdef AUTO_RESTART_EN
        if (hold_cnt_q == HOLD_LAST) begin
          state_d      = P1;
          player_win_d = 1'b0;
          dealer_win_d = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      player_win_q <= 1'b0;
      dealer_win_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      player_win_q <= player_win_d;
      dealer_win_q <= dealer_win_d;
    end
  end

  assign load_pcard1      = (state_q == P1);
  assign load_dcard1      = (state_q == D1);
  assign load_pcard2      = (state_q == P2);
  assign load_dcard2      = (state_q == D2);
  assign load_pcard3      = (state_q == P3);
  assign load_dcard3      = (state_q == D3);
  assign round_done       = (state_q == DONE);
  assign player_win_light = player_win_q;
  assign dealer_win_light = dealer_win_q;

endmodule

`default_nettype wire

// File: tb/tb_baccarat_controller.sv
// ============================================================================
// tb_baccarat_controller : directed rounds with a queued expected-event monitor.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_baccarat_controller;

  logic       slow_clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] pscore_in = 4'd0;
  logic [3:0] dscore_in = 4'd0;
  logic [3:0] pcard3_in = 4'd0;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light, round_done;

  baccarat_controller #(.HOLD_CYCLES(4)) dut (
    .slow_clock       (slow_clock),
    .reset            (reset),
    .pscore_in        (pscore_in),
    .dscore_in        (dscore_in),
    .pcard3_in        (pcard3_in),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .round_done       (round_done)
  );

  always #5 slow_clock = ~slow_clock;

  // Event codes: 0 pcard1, 1 dcard1, 2 pcard2, 3 dcard2, 4 pcard3, 5 dcard3, 6 done.
  typedef struct {
    int         code;
    int         cyc;
    logic [1:0] lights;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  wire [5:0] strobes = {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};
  wire [8:0] all_out = {strobes, player_win_light, dealer_win_light, round_done};

  always @(posedge slow_clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int code, input int c, input logic [1:0] l);
    exp_t e;
    e.code = code; e.cyc = c; e.lights = l;
    q.push_back(e);
  endfunction

  // Expected events of a round, from hand-computed draw decisions.
  function automatic void push_round(input bit pdraw, input bit ddraw, input logic [1:0] l);
    int t;
    push(0, 1, 2'b00); push(1, 2, 2'b00); push(2, 3, 2'b00); push(3, 4, 2'b00);
    t = 5;
    if (pdraw) begin push(4, t + 1, 2'b00); t = t + 2; end
    if (ddraw) begin push(5, t + 1, 2'b00); t = t + 1; end
    push(6, t + 2, l);
  endfunction

  // Monitor: every strobe cycle and every rising round_done pops one expectation.
  initial begin
    logic done_prev;
    exp_t e;
    int   code;
    done_prev = 1'b0;
    forever begin
      @(negedge slow_clock);
      if (!reset) begin
        if (|strobes) begin
          code = 0;
          for (int i = 0; i < 6; i++) if (strobes[i]) code = i;
          chk("strobe_onehot", $countones(strobes), 1);
          if (q.size() == 0) begin
            chk("unexpected_strobe", code, -1);
          end else begin
            e = q.pop_front();
            chk("strobe_code", code, e.code);
            chk("strobe_cycle", cyc, e.cyc);
          end
        end
        if (round_done && !done_prev) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 6, -1);
          end else begin
            e = q.pop_front();
            chk("done_code", 6, e.code);
            chk("done_cycle", cyc, e.cyc);
            chk("done_lights", int'({player_win_light, dealer_win_light}), int'(e.lights));
          end
        end
      end
      done_prev = round_done;
    end
  end

  task automatic assert_reset();
    #2 reset = 1'b1;
    #1 chk("async_reset_outputs", int'(all_out), 0);
    repeat (2) @(posedge slow_clock);
    @(negedge slow_clock);
    chk("held_reset_outputs", int'(all_out), 0);
  endtask

  task automatic run_round(input logic [3:0] p, input logic [3:0] d, input logic [3:0] c3,
                           input bit pdraw, input bit ddraw, input logic [1:0] l);
    assert_reset();
    pscore_in = p; dscore_in = d; pcard3_in = c3;
    push_round(pdraw, ddraw, l);
    @(negedge slow_clock);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge slow_clock);
      if (round_done) break;
    end
    chk("round_done_reached", int'(round_done), 1);
    repeat (3) @(negedge slow_clock);
    chk("done_held", int'(round_done), 1);
    chk("lights_held", int'({player_win_light, dealer_win_light}), int'(l));
    chk("queue_drained", q.size(), 0);
    q.delete();
  endtask

  typedef struct {
    logic [3:0] p, d, c3;
    bit         pdraw, ddraw;
    logic [1:0] l;
  } vec_t;

  vec_t vecs[$];

  initial begin
    //                p      d      c3     pd  dd  {player,dealer}
    vecs.push_back('{4'd8,  4'd3, 4'd0,  0,  0, 2'b10});
    vecs.push_back('{4'd4,  4'd6, 4'd7,  1,  1, 2'b01});
    vecs.push_back('{4'd4,  4'd6, 4'd8,  1,  0, 2'b01});
    vecs.push_back('{4'd7,  4'd5, 4'd0,  0,  1, 2'b10});
    vecs.push_back('{4'd7,  4'd7, 4'd0,  0,  0, 2'b11});
    vecs.push_back('{4'd2,  4'd9, 4'd0,  0,  0, 2'b01});
    vecs.push_back('{4'd15, 4'd0, 4'd0,  0,  0, 2'b10});
    vecs.push_back('{4'd5,  4'd3, 4'd8,  1,  0, 2'b10});
    vecs.push_back('{4'd5,  4'd3, 4'd9,  1,  1, 2'b10});
    vecs.push_back('{4'd6,  4'd4, 4'd0,  0,  1, 2'b10});
    vecs.push_back('{4'd1,  4'd6, 4'd6,  1,  1, 2'b01});
    vecs.push_back('{4'd0,  4'd7, 4'd5,  1,  0, 2'b01});
    vecs.push_back('{4'd3,  4'd5, 4'd3,  1,  0, 2'b01});
    vecs.push_back('{4'd3,  4'd4, 4'd2,  1,  1, 2'b01});
    vecs.push_back('{4'd3,  4'd4, 4'd1,  1,  0, 2'b01});
    vecs.push_back('{4'd0,  4'd2, 4'd0,  1,  1, 2'b01});

    foreach (vecs[i])
      run_round(vecs[i].p, vecs[i].d, vecs[i].c3, vecs[i].pdraw, vecs[i].ddraw, vecs[i].l);

    // Reset in the middle of the P3 cycle, then a fresh natural round.
    assert_reset();
    pscore_in = 4'd4; dscore_in = 4'd6; pcard3_in = 4'd7;
    push(0, 1, 2'b00); push(1, 2, 2'b00); push(2, 3, 2'b00); push(3, 4, 2'b00); push(4, 6, 2'b00);
    @(negedge slow_clock);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge slow_clock);
      if (load_pcard3) break;
    end
    chk("pcard3_reached", int'(load_pcard3), 1);
    #2 reset = 1'b1;
    #1 chk("pcard3_async_drop", int'(load_pcard3), 0);
    chk("midreset_outputs", int'(all_out), 0);
    chk("midreset_queue", q.size(), 0);
    q.delete();
    run_round(4'd8, 4'd3, 4'd0, 0, 0, 2'b10);

`ifdef AUTO_RESTART_EN
    begin
      int n;
      assert_reset();
      pscore_in = 4'd7; dscore_in = 4'd7; pcard3_in = 4'd0;
      push_round(0, 0, 2'b11);
      push(0, 11, 2'b00);
      @(negedge slow_clock);
      reset = 1'b0;
      n = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge slow_clock);
        if (round_done) n++;
        if (load_pcard1 && cyc > 1) break;
      end
      chk("hold_cycles", n, 4);
      chk("restart_pcard1", int'(load_pcard1), 1);
      chk("restart_lights", int'({player_win_light, dealer_win_light, round_done}), 0);
      chk("restart_queue", q.size(), 0);
      q.delete();
    end
`endif

    assert_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
